systolic_operand_feeder: RTL and testbench

Drives the west (A) and north (B) edges of an N×N systolic array of PE modules. Each job is a sequence of K operand slices: column k of A and row k of B. The block skews the slices so that lane i reaches the array edge i cycles after lane 0. This delivers the wavefront timing the PEs need to pass a/b neighbour-to-neighbour. The block is the transmitting end of the PE a/b operand stream. It also emits the accumulator-clear pulse before a job and a done pulse once the last operand has left the edge.

---
 rtl/systolic_operand_feeder_pkg.sv | 6 +
 rtl/systolic_operand_feeder_if.sv | 27 ++
 rtl/systolic_operand_feeder_skew.sv | 30 +++
 rtl/systolic_operand_feeder.sv | 65 ++++++
 tb/tb_systolic_operand_feeder.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/systolic_operand_feeder_pkg.sv
// systolic_pkg: array sizing defaults and feeder state encoding shared across the array
package systolic_pkg;
  localparam int N_DEF = 4;
  localparam int W_DEF = 8;
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} feeder_state_t;
endpackage

// File: rtl/systolic_operand_feeder_if.sv
// systolic_operand_feeder_if: job control, slice input and skewed edge outputs of the feeder
interface systolic_operand_feeder_if
  import systolic_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
);
  logic           start;
  logic           busy;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_a;
  logic [N*W-1:0] in_b;
  logic [N*W-1:0] a_edge;
  logic [N*W-1:0] b_edge;
  logic [N-1:0]   edge_valid;
  logic           acc_clr;
  logic           done;
  modport master (
    output start, in_valid, in_a, in_b,
    input  busy, in_ready, a_edge, b_edge, edge_valid, acc_clr, done
  );
  modport slave (
    input  start, in_valid, in_a, in_b,
    output busy, in_ready, a_edge, b_edge, edge_valid, acc_clr, done
  );
endinterface

// File: rtl/systolic_operand_feeder_skew.sv
// skew_delay_line: DEPTH-stage {valid, data} shift register that skews one operand lane
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic [DEPTH-1:0]        r_v;
  logic [DEPTH-1:0][W-1:0] r_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      r_d <= '0;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_v[k] <= r_v[k-1];
        r_d[k] <= r_d[k-1];
      end
      r_v[0] <= i_valid;
      r_d[0] <= i_data;
    end
  end
  assign o_valid = r_v[DEPTH-1];
  assign o_data  = r_d[DEPTH-1];
endmodule

// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder: skews A/B operand slices onto the systolic array edges with clear/done pulses
module systolic_operand_feeder
  import systolic_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF,
  parameter int K = 4
) (
  input logic                    clk,
  input logic                    rst,
  systolic_operand_feeder_if.slave bus
);
  localparam int CW = $clog2(K + 1);
  localparam int FW = $clog2(N + 1);
  feeder_state_t           r_state, w_next;
  logic [CW-1:0]           r_cnt;
  logic [FW-1:0]           r_fl;
  logic                    r_clr;
  logic                    w_acc;
  logic [N-1:0]            w_va, w_vb;
  logic [N-1:0][W-1:0]     w_a, w_b;
  assign w_acc = bus.in_valid && r_state == FEED;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = bus.start ? FEED : IDLE;
      FEED:    w_next = (w_acc && r_cnt == CW'(K - 1)) ? FLUSH : FEED;
      FLUSH:   w_next = (r_fl == FW'(N - 1)) ? DONE : FLUSH;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_fl    <= '0;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_state == IDLE ? '0 : r_cnt + CW'(w_acc);
      r_fl    <= r_state == FLUSH ? r_fl + 1'b1 : '0;
      r_clr   <= r_state == IDLE && bus.start;
    end
  end
  assign bus.in_ready = r_state == FEED;
  assign bus.busy     = r_state != IDLE;
  assign bus.done     = r_state == DONE;
  assign bus.acc_clr  = r_clr;
  // lane i carries i+1 stages so operands land on the diagonal wavefront
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(.DEPTH(i + 1), .W(W)) u_a (
      .clk(clk), .rst(rst), .i_valid(w_acc),
      .i_data(w_acc ? bus.in_a[i*W +: W] : '0),
      .o_valid(w_va[i]), .o_data(w_a[i])
    );
    skew_delay_line #(.DEPTH(i + 1), .W(W)) u_b (
      .clk(clk), .rst(rst), .i_valid(w_acc),
      .i_data(w_acc ? bus.in_b[i*W +: W] : '0),
      .o_valid(w_vb[i]), .o_data(w_b[i])
    );
  end
  assign bus.a_edge     = w_a;
  assign bus.b_edge     = w_b;
  assign bus.edge_valid = w_va & w_vb;
endmodule

// File: tb/tb_systolic_operand_feeder.sv
// tb_systolic_operand_feeder: directed and randomized checks against an event-level feeder model
module tb_systolic_operand_feeder;
  localparam int N = 4;
  localparam int W = 8;
  localparam int K = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  systolic_operand_feeder_if #(.N(N), .W(W)) if4 ();
  systolic_operand_feeder_if #(.N(N), .W(W)) if1 ();
  systolic_operand_feeder #(.N(N), .W(W), .K(K)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  systolic_operand_feeder #(.N(N), .W(W), .K(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: a job is the start edge, the list of accept edges, and done at last accept + N.
  int t = 0, m_s = 0, m_last = -1, m_cnt = 0;
  bit m_busy = 0;
  bit h_v[16];
  logic [N*W-1:0] h_a[16], h_b[16];
  bit e_busy, e_rdy, e_clr, e_done;
  logic [N-1:0] e_v;
  logic [N*W-1:0] e_a, e_b;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0;
      for (int j = 0; j < 16; j++) h_v[j] = 0;
    end else begin
      t++;
      h_v[t%16] = 0;
      if (m_busy) begin
        if (m_last < 0 && t > m_s && if4.in_valid) begin
          h_v[t%16] = 1;
          h_a[t%16] = if4.in_a;
          h_b[t%16] = if4.in_b;
          m_cnt++;
          if (m_cnt == K) m_last = t;
        end else if (m_last >= 0 && t == m_last + N + 1) m_busy = 0;
      end else if (if4.start) begin
        m_busy = 1; m_s = t; m_cnt = 0; m_last = -1;
      end
    end
    e_busy = m_busy;
    e_rdy  = m_busy && m_last < 0;
    e_clr  = m_busy && t == m_s;
    e_done = m_busy && m_last >= 0 && t == m_last + N;
    for (int i = 0; i < N; i++) begin
      int x;
      x = (t - i + 16) % 16;
      e_v[i] = h_v[x];
      e_a[i*W +: W] = h_v[x] ? h_a[x][i*W +: W] : '0;
      e_b[i*W +: W] = h_v[x] ? h_b[x][i*W +: W] : '0;
    end
  end

  always @(negedge clk) begin
    chk("busy", if4.busy, e_busy);
    chk("in_ready", if4.in_ready, e_rdy);
    chk("acc_clr", if4.acc_clr, e_clr);
    chk("done", if4.done, e_done);
    chk("edge_valid", if4.edge_valid, e_v);
    chk("a_edge", if4.a_edge, e_a);
    chk("b_edge", if4.b_edge, e_b);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slice(input int k);
    for (int i = 0; i < N; i++) begin
      if4.in_a[i*W +: W] = W'(16 * k + i);
      if4.in_b[i*W +: W] = W'(8'h80 + 16 * k + i);
    end
  endtask

  initial begin
    int bc, d;
    if4.start = 0; if4.in_valid = 0; if4.in_a = '0; if4.in_b = '0;
    if1.start = 0; if1.in_valid = 0; if1.in_a = '0; if1.in_b = '0;
    step(); step();
    chk("rst_busy", if4.busy, 0);
    chk("rst_ready", if4.in_ready, 0);
    chk("rst_ev", if4.edge_valid, 0);
    rst = 0;
    step();
    // back-to-back job
    if4.start = 1; step(); if4.start = 0;
    chk("b2b_clr", if4.acc_clr, 1);
    chk("b2b_ready", if4.in_ready, 1);
    if4.in_valid = 1;
    slice(0); step();
    chk("b2b_ev0", if4.edge_valid, 4'b0001);
    chk("b2b_clr_once", if4.acc_clr, 0);
    slice(1); step(); slice(2); step(); slice(3); step();
    chk("b2b_ev_full", if4.edge_valid, 4'b1111);
    chk("b2b_a_diag", if4.a_edge, 32'h03122130);
    chk("b2b_b_diag", if4.b_edge, 32'h8392A1B0);
    if4.in_valid = 0;
    step(); step(); step();
    chk("b2b_ev_tail", if4.edge_valid, 4'b1000);
    chk("b2b_a_tail", if4.a_edge, 32'h33000000);
    step();
    chk("b2b_done", if4.done, 1);
    chk("b2b_ev_empty", if4.edge_valid, 0);
    step();
    chk("b2b_idle", if4.busy, 0);
    // bubbles between slice 1 and slice 2
    if4.start = 1; step(); if4.start = 0;
    if4.in_valid = 1; slice(0); step(); slice(1); step();
    if4.in_valid = 0; step();
    chk("bub_ev1", if4.edge_valid, 4'b0110);
    step();
    chk("bub_ev2", if4.edge_valid, 4'b1100);
    if4.in_valid = 1; slice(2); step(); slice(3); step();
    if4.in_valid = 0; step(); step(); step();
    chk("bub_not_done", if4.done, 0);
    step();
    chk("bub_done", if4.done, 1);
    step();
    // ignored inputs
    if4.in_valid = 1; slice(5); step(); step();
    chk("idle_ev", if4.edge_valid, 0);
    chk("idle_ready", if4.in_ready, 0);
    if4.in_valid = 0; if4.start = 1; step(); if4.start = 0;
    if4.in_valid = 1; slice(0); step();
    if4.start = 1; slice(1); step(); if4.start = 0;
    chk("restart_clr", if4.acc_clr, 0);
    slice(2); step(); slice(3); step();
    if4.in_valid = 0; step(); step(); step(); step();
    chk("restart_done", if4.done, 1);
    step();
    // reset during FLUSH
    if4.start = 1; step(); if4.start = 0;
    if4.in_valid = 1;
    for (int k = 0; k < K; k++) begin slice(k); step(); end
    if4.in_valid = 0; step(); step();
    #2 rst = 1; #1;
    chk("frst_ev", if4.edge_valid, 0);
    chk("frst_a", if4.a_edge, 0);
    chk("frst_b", if4.b_edge, 0);
    chk("frst_busy", if4.busy, 0);
    chk("frst_done", if4.done, 0);
    step(); rst = 0; step();
    chk("frst_no_done", if4.done, 0);
    if4.start = 1; step(); if4.start = 0;
    if4.in_valid = 1; if4.in_a = '1; if4.in_b = '1;
    step(); step(); step(); step();
    chk("ff_ev", if4.edge_valid, 4'b1111);
    chk("ff_a", if4.a_edge, 32'hFFFFFFFF);
    chk("ff_b", if4.b_edge, 32'hFFFFFFFF);
    if4.in_valid = 0;
    for (int j = 0; j < 6; j++) step();
    // randomized traffic, occasional async reset
    for (int c = 0; c < 1500; c++) begin
      if4.start = ($urandom % 5) == 0;
      if4.in_valid = ($urandom % 3) != 0;
      if4.in_a = $urandom;
      if4.in_b = $urandom;
      if (($urandom % 120) == 0) begin
        #3 rst = 1; #3 rst = 0;
      end
      step();
    end
    if4.start = 0; if4.in_valid = 0;
    for (int j = 0; j < 12; j++) step();
    // K=1 instance
    if1.start = 1; step(); if1.start = 0;
    chk("k1_busy", if1.busy, 1);
    if1.in_valid = 1; if1.in_a = 32'h5A5A5A5A; if1.in_b = 32'hC3C3C3C3;
    step(); if1.in_valid = 0;
    chk("k1_ev", if1.edge_valid, 4'b0001);
    chk("k1_a0", if1.a_edge[7:0], 8'h5A);
    chk("k1_ready", if1.in_ready, 0);
    bc = 2; d = 0;
    for (int j = 1; j <= 10; j++) begin
      step();
      if (if1.done) d = j;
      if (if1.busy) bc++;
    end
    chk("k1_done_delay", d, 4);
    chk("k1_busy_cycles", bc, 6);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
